uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 11 +
 rtl/byte_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state encoding.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // start + 8 data + stop
  localparam int FRAME_BITS           = 10;
  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with first-word-fall-through read and a
// registered occupancy count; full/empty come from the count.
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Writes while full and reads while empty are dropped here, so callers
  // need not gate them.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array: no reset, contents are only meaningful below count.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a FIFO,
// frames serialised LSB-first back-to-back while bytes are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int FIFO_DEPTH   = 16,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          UART_TX,
  output logic          tx_busy,
  output logic [LW-1:0] fifo_level
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic          bit_end;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign UART_TX  = tx_q;
  assign tx_busy  = busy_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_level)
  );

  // Frame sequencing: next state, baud count, shift register and line level.
  // The line value is computed one cycle ahead so UART_TX is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Transmitter state; reset forces the line high immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with 4 clocks per bit and a 4-deep FIFO.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int LW  = $clog2(DEP) + 1;

  logic          CLK;
  logic          RST_N;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          UART_TX;
  logic          tx_busy;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .UART_TX    (UART_TX),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Line decoder: collects received bytes, counts bad stop bits.
  logic [7:0] rxq[$];
  int         stop_err = 0;
  initial begin
    logic       act;
    int         n;
    logic [7:0] sh;
    act = 1'b0;
    n   = 0;
    sh  = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        act = 1'b0;
      end else if (!act) begin
        if (UART_TX === 1'b0) begin
          act = 1'b1;
          n   = 1;
        end
      end else begin
        if (n % CPB == 2 && n >= CPB + 2 && n <= 8 * CPB + 2) sh = {UART_TX, sh[7:1]};
        if (n == 9 * CPB + 2) begin
          if (UART_TX !== 1'b1) stop_err++;
          rxq.push_back(sh);
        end
        if (n == 10 * CPB - 1) act = 1'b0;
        n++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Checks every cycle of one frame starting at the current (start-bit) cycle.
  task automatic frame(input logic [7:0] b, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("%s_bit%0d_c%0d", tag, i, c), UART_TX, bits[i]);
        chk($sformatf("%s_busy", tag), tx_busy, 1);
        step();
      end
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_tx", UART_TX, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", in_ready, 1);
    RST_N = 1'b1;
    step();

    // 1: single byte 0x55
    in_valid = 1'b1;
    in_data  = 8'h55;
    chk("t1_pre_tx", UART_TX, 1);
    step();
    in_valid = 1'b0;
    chk("t1_push_tx", UART_TX, 1);
    chk("t1_push_level", fifo_level, 1);
    step();
    chk("t1_level0", fifo_level, 0);
    frame(8'h55, "t1");
    chk("t1_after_tx", UART_TX, 1);
    chk("t1_after_busy", tx_busy, 0);
    step();
    chk("t1_idle_tx", UART_TX, 1);

    // 2: back-to-back 0xA3, 0x0F
    in_valid = 1'b1;
    in_data  = 8'hA3;
    step();
    chk("t2_level_a", fifo_level, 1);
    in_data = 8'h0F;
    step();
    in_valid = 1'b0;
    chk("t2_level_b", fifo_level, 1);
    frame(8'hA3, "t2a");
    chk("t2_level_c", fifo_level, 0);
    frame(8'h0F, "t2b");
    chk("t2_after_tx", UART_TX, 1);
    chk("t2_after_busy", tx_busy, 0);
    chk("t12_rx_count", rxq.size(), 3);
    if (rxq.size() == 3) begin
      chk("t12_rx0", rxq[0], 8'h55);
      chk("t12_rx1", rxq[1], 8'hA3);
      chk("t12_rx2", rxq[2], 8'h0F);
    end
    rxq.delete();
    step();

    // 3+4: stream 0x01..0x06 into a 4-deep FIFO, 0xEE offered while full
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    chk("t3_e1_level", fifo_level, 1);
    chk("t3_e1_ready", in_ready, 1);
    in_data = 8'h02;
    step();
    chk("t3_e2_level", fifo_level, 1);
    chk("t3_e2_tx", UART_TX, 0);
    chk("t3_e2_busy", tx_busy, 1);
    in_data = 8'h03;
    step();
    chk("t3_e3_level", fifo_level, 2);
    in_data = 8'h04;
    step();
    chk("t3_e4_level", fifo_level, 3);
    in_data = 8'h05;
    step();
    chk("t3_e5_level", fifo_level, 4);
    chk("t3_e5_ready", in_ready, 0);
    in_data = 8'hEE;
    for (int e = 6; e <= 41; e++) begin
      step();
      chk($sformatf("t4_full_level_e%0d", e), fifo_level, 4);
      chk($sformatf("t4_full_ready_e%0d", e), in_ready, 0);
    end
    in_data = 8'h06;
    step();
    chk("t3_e42_level", fifo_level, 3);
    chk("t3_e42_ready", in_ready, 1);
    chk("t3_e42_tx", UART_TX, 0);
    step();
    in_valid = 1'b0;
    chk("t3_e43_level", fifo_level, 4);
    chk("t3_e43_ready", in_ready, 0);
    for (int i = 0; i < 400 && (rxq.size() < 6 || tx_busy); i++) step();
    chk("t3_rx_count", rxq.size(), 6);
    if (rxq.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("t3_rx%0d", i), rxq[i], i + 1);
    end
    chk("t3_end_level", fifo_level, 0);
    chk("t3_end_busy", tx_busy, 0);
    rxq.delete();
    step();

    // 5: reset during DATA of 0x55 with 3 bytes queued
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    in_data = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_data = 8'h33;
    step();
    in_valid = 1'b0;
    chk("t5_level_q", fifo_level, 3);
    repeat (6) step();
    chk("t5_data_tx", UART_TX, 0);
    chk("t5_data_busy", tx_busy, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("t5_rst_tx", UART_TX, 1);
    chk("t5_rst_busy", tx_busy, 0);
    chk("t5_rst_level", fifo_level, 0);
    chk("t5_rst_ready", in_ready, 1);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    step();
    rxq.delete();
    for (int i = 0; i < 100; i++) begin
      chk("t5_quiet_tx", UART_TX, 1);
      chk("t5_quiet_busy", tx_busy, 0);
      step();
    end
    chk("t5_rx_none", rxq.size(), 0);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    in_valid = 1'b0;
    step();
    frame(8'h3C, "t5_new");
    chk("t5_new_end_tx", UART_TX, 1);

    // 6: idle line
    for (int i = 0; i < 1000; i++) begin
      chk("t6_tx", UART_TX, 1);
      chk("t6_busy", tx_busy, 0);
      chk("t6_ready", in_ready, 1);
      step();
    end
    chk("stop_bits", stop_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
